cpu_seq_ctrl: RTL and testbench

- Eight-phase instruction sequencer directly upstream of the ALU stage.
- Latches the 3-bit opcode fetched into the instruction register and drives the opcode bus consumed by the ALU.
- Generates per-phase datapath strobes (memory select/read/write, IR load, PC increment/load, accumulator load, data-bus enable, halt).
- Samples the ALU zero flag for conditional skip.

---
 rtl/cpu_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl - eight-phase instruction sequencer feeding the ALU stage.
//
// Steps through INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH,
// ALU_OP and STORE, one phase per clock. It latches the fetched opcode and
// decodes the per-phase datapath strobes. A HLT instruction freezes the
// sequencer in OP_FETCH until a resume pulse arrives.
//
// Optional feature macro: CTRL_ICOUNT_EN. When it is defined, the block
// counts retired instructions on instr_count. Otherwise instr_count is
// tied to zero.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   ir_opcode   in   opcode field of the instruction register (sampled in INST_LOAD)
//   zero        in   ALU zero flag (only used in ALU_OP)
//   resume      in   single-cycle pulse releasing a halt
//   opcode      out  latched opcode to the ALU
//   sel         out  address mux select (1 = PC, 0 = IR operand)
//   rd, wr      out  memory read / write
//   ld_ir       out  instruction register load
//   inc_pc      out  PC increment
//   ld_pc       out  PC load (jump)
//   ld_ac       out  accumulator load
//   data_e      out  accumulator drives data bus
//   halt        out  processor halted (sticky until resume)
//   instr_count out  retired instruction count (zero unless CTRL_ICOUNT_EN)
module cpu_seq_ctrl #(
  parameter int OP_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_WIDTH-1:0]  ir_opcode,
  input  logic                 zero,
  input  logic                 resume,
  output logic [OP_WIDTH-1:0]  opcode,
  output logic                 sel,
  output logic                 rd,
  output logic                 wr,
  output logic                 ld_ir,
  output logic                 inc_pc,
  output logic                 ld_pc,
  output logic                 ld_ac,
  output logic                 data_e,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(3'd0);
  localparam logic [OP_WIDTH-1:0] OP_SKZ = OP_WIDTH'(3'd1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(3'd2);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3'd3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(3'd4);
  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(3'd5);
  localparam logic [OP_WIDTH-1:0] OP_STO = OP_WIDTH'(3'd6);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(3'd7);

  phase_t              phase_r;
  phase_t              phase_next_s;
  logic                halted_r;
  logic                halted_next_s;
  logic [OP_WIDTH-1:0] opcode_r;
  logic                aluop_s;
  // Strobe vector order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e}
  logic [7:0]          strobe_s;

  assign aluop_s = (opcode_r == OP_ADD) || (opcode_r == OP_AND) ||
                   (opcode_r == OP_XOR) || (opcode_r == OP_LDA);

  // Next-phase and halt-flag logic.
  always_comb begin
    phase_next_s  = phase_r;
    halted_next_s = halted_r;
    if (halted_r) begin
      // Phase is frozen in OP_FETCH. Resume only clears the flag, so the
      // following cycle is a live OP_FETCH and the instruction keeps 8 active clocks.
      phase_next_s  = phase_r;
      halted_next_s = resume ? 1'b0 : 1'b1;
    end else begin
      phase_next_s  = phase_t'(phase_r + 3'd1);
      // A halt can only arise here, and resume is ignored when not halted, so halt wins.
      halted_next_s = (phase_r == OP_ADDR) && (opcode_r == OP_HLT);
    end
  end

  // Strobe decode from phase, latched opcode and zero flag.
  always_comb begin
    strobe_s = 8'h00;
    if (halted_r) begin
      strobe_s = 8'h00;
    end else begin
      case (phase_r)
        INST_ADDR:  strobe_s = 8'b1000_0000;
        INST_FETCH: strobe_s = 8'b1100_0000;
        INST_LOAD:  strobe_s = 8'b1101_0000;
        IDLE:       strobe_s = 8'b1101_0000;
        OP_ADDR:    strobe_s = 8'b0000_1000;
        OP_FETCH:   strobe_s = {1'b0, aluop_s, 6'b00_0000};
        ALU_OP:     strobe_s = {1'b0, aluop_s, 1'b0, 1'b0,
                                (opcode_r == OP_SKZ) && zero,
                                (opcode_r == OP_JMP), 1'b0,
                                (opcode_r == OP_STO)};
        STORE:      strobe_s = {1'b0, aluop_s, (opcode_r == OP_STO), 1'b0,
                                (opcode_r == OP_JMP), (opcode_r == OP_JMP),
                                aluop_s, (opcode_r == OP_STO)};
        default:    strobe_s = 8'h00;
      endcase
    end
  end

  assign {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e} = strobe_s;
  assign opcode = opcode_r;
  assign halt   = halted_r;

  // Phase, halt flag and opcode latch registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r  <= INST_ADDR;
      halted_r <= 1'b0;
      opcode_r <= OP_HLT;
    end else begin
      phase_r  <= phase_next_s;
      halted_r <= halted_next_s;
      if (phase_r == INST_LOAD) begin
        opcode_r <= ir_opcode;
      end else begin
        opcode_r <= opcode_r;
      end
    end
  end

`ifdef CTRL_ICOUNT_EN
  logic [CNT_WIDTH-1:0] count_r;

  // Retired-instruction counter, bumped on each STORE -> INST_ADDR step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if ((phase_r == STORE) && !halted_r) begin
      count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;
`else
  assign instr_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed, table-driven testbench for cpu_seq_ctrl.
module tb_cpu_seq_ctrl;

  localparam int CNT_WIDTH = 16;
`ifdef CTRL_ICOUNT_EN
  localparam bit ICNT = 1'b1;
`else
  localparam bit ICNT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [2:0]           ir_opcode;
  logic                 zero;
  logic                 resume;
  logic [2:0]           opcode;
  logic                 sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [CNT_WIDTH-1:0] instr_count;

  cpu_seq_ctrl #(.OP_WIDTH(3), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .ir_opcode(ir_opcode), .zero(zero), .resume(resume),
    .opcode(opcode), .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .halt(halt),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ir;
    logic       zero;
    logic       resume;
    logic [2:0] exp_op;
    logic [7:0] exp_st;  // {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e}
  } vec_t;

  vec_t                 vecs[64];
  int                   nvec = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   step_idx = 0;
  logic [CNT_WIDTH-1:0] exp_cnt = '0;

  function automatic logic [7:0] strobes();
    return {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One instruction: phases 0..4 are opcode independent, 5..7 given by caller.
  // ir_opcode carries the real opcode only in INST_LOAD; LDA elsewhere.
  task automatic add_instr(input logic [2:0] op, input logic [2:0] prev,
                           input logic [7:0] zmask, input logic [7:0] s5,
                           input logic [7:0] s6, input logic [7:0] s7);
    for (int p = 0; p < 8; p++) begin
      vecs[nvec].ir     = (p == 2) ? op : 3'd5;
      vecs[nvec].zero   = zmask[p];
      vecs[nvec].resume = (p == 1);
      vecs[nvec].exp_op = (p < 3) ? prev : op;
      case (p)
        0:       vecs[nvec].exp_st = 8'b1000_0000;
        1:       vecs[nvec].exp_st = 8'b1100_0000;
        2:       vecs[nvec].exp_st = 8'b1101_0000;
        3:       vecs[nvec].exp_st = 8'b1101_0000;
        4:       vecs[nvec].exp_st = 8'b0000_1000;
        5:       vecs[nvec].exp_st = s5;
        6:       vecs[nvec].exp_st = s6;
        default: vecs[nvec].exp_st = s7;
      endcase
      nvec++;
    end
  endtask

  // Drive one cycle, check mid-cycle, then advance past the next rising edge.
  task automatic step(input logic [2:0] ir, input logic z, input logic res,
                      input logic [7:0] exp_st, input logic [2:0] exp_op,
                      input logic exp_halt, input string name);
    ir_opcode = ir;
    zero      = z;
    resume    = res;
    @(negedge clk);
    check({name, " strobes"}, step_idx, 32'(strobes()), 32'(exp_st));
    check({name, " opcode"}, step_idx, 32'(opcode), 32'(exp_op));
    check({name, " halt"}, step_idx, 32'(halt), 32'(exp_halt));
    check({name, " count"}, step_idx, 32'(instr_count), ICNT ? 32'(exp_cnt) : 32'd0);
    step_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    ir_opcode = 3'd0;
    zero      = 1'b0;
    resume    = 1'b0;

    // Expected strobes for phases 5,6,7 of each instruction.
    add_instr(3'd2, 3'd0, 8'h00,        8'b0100_0000, 8'b0100_0000, 8'b0100_0010); // ADD
    add_instr(3'd6, 3'd2, 8'h00,        8'b0000_0000, 8'b0000_0001, 8'b0010_0001); // STO
    add_instr(3'd1, 3'd6, 8'b0100_0000, 8'b0000_0000, 8'b0000_1000, 8'b0000_0000); // SKZ, zero=1
    add_instr(3'd1, 3'd1, 8'b1011_1111, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000); // SKZ, zero=0 in ALU_OP
    add_instr(3'd1, 3'd1, 8'b0010_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000); // SKZ, zero in OP_FETCH only
    add_instr(3'd7, 3'd1, 8'h00,        8'b0000_0000, 8'b0000_0100, 8'b0000_1100); // JMP

    // Reset state
    #12;
    check("reset strobes", 0, 32'(strobes()), 32'h80);
    check("reset opcode", 0, 32'(opcode), 32'd0);
    check("reset halt", 0, 32'(halt), 32'd0);
    check("reset count", 0, 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table-driven instruction vectors
    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].ir, vecs[i].zero, vecs[i].resume, vecs[i].exp_st,
           vecs[i].exp_op, 1'b0, "vec");
      if ((i % 8) == 7) exp_cnt = exp_cnt + 16'd1;
    end

    // HLT: OP_ADDR inc_pc fires, then frozen with all strobes low
    step(3'd5, 1'b0, 1'b0, 8'b1000_0000, 3'd7, 1'b0, "hlt p0");
    step(3'd5, 1'b0, 1'b0, 8'b1100_0000, 3'd7, 1'b0, "hlt p1");
    step(3'd0, 1'b0, 1'b0, 8'b1101_0000, 3'd7, 1'b0, "hlt p2");
    step(3'd5, 1'b0, 1'b0, 8'b1101_0000, 3'd0, 1'b0, "hlt p3");
    step(3'd5, 1'b0, 1'b0, 8'b0000_1000, 3'd0, 1'b0, "hlt p4");
    for (int i = 0; i < 20; i++) begin
      step(3'd5, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, "halted");
    end
    step(3'd5, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, "resume cyc");
    step(3'd5, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "post op_fetch");
    step(3'd5, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, "post alu_op");
    step(3'd5, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "post store");
    exp_cnt = exp_cnt + 16'd1;

    // ADD interrupted by asynchronous reset in OP_FETCH
    step(3'd5, 1'b0, 1'b0, 8'b1000_0000, 3'd0, 1'b0, "abort p0");
    step(3'd5, 1'b0, 1'b0, 8'b1100_0000, 3'd0, 1'b0, "abort p1");
    step(3'd2, 1'b0, 1'b0, 8'b1101_0000, 3'd0, 1'b0, "abort p2");
    step(3'd5, 1'b0, 1'b0, 8'b1101_0000, 3'd2, 1'b0, "abort p3");
    step(3'd5, 1'b0, 1'b0, 8'b0000_1000, 3'd2, 1'b0, "abort p4");
    @(negedge clk);
    check("abort p5 strobes", 0, 32'(strobes()), 32'h40);
    reset = 1'b0;
    #1;
    check("async reset strobes", 0, 32'(strobes()), 32'h80);
    check("async reset opcode", 0, 32'(opcode), 32'd0);
    check("async reset halt", 0, 32'(halt), 32'd0);
    check("async reset count", 0, 32'(instr_count), 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(3'd5, 1'b0, 1'b0, 8'b1000_0000, 3'd0, 1'b0, "restart p0");
    step(3'd5, 1'b0, 1'b0, 8'b1100_0000, 3'd0, 1'b0, "restart p1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
